// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage MIPS pipeline.
//
// Holds the word-addressed data RAM, resolves the branch decision and
// stretches loads/stores by LAT wait cycles. The stage ends in the MEM/WB
// pipeline register that feeds write-back.
//
// Parameters:
//   DEPTH  data RAM size in 32-bit words (power of two, 4..1024)
//   LAT    extra wait cycles per load/store (0..7, 0 = single-cycle access)
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   regWriteM       register write enable from EX/MEM
//   MemToRegM       load instruction
//   MemWriteM       store instruction
//   BranchM, ZeroM  branch instruction and ALU zero flag
//   ALUOutM         ALU result / byte address
//   WriteDataM      store data
//   WriteRegM       destination register
//   PCSrcM          branch taken (combinational)
//   StallM          memory busy; upstream stages hold while high
//   regWriteW, MemToRegW, ReadDataW, ALUOutW, WriteRegW
//                   MEM/WB register outputs to write-back
module mem_stage #(
    parameter int DEPTH = 64,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        regWriteM,
    input  logic        MemToRegM,
    input  logic        MemWriteM,
    input  logic        BranchM,
    input  logic        ZeroM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        PCSrcM,
    output logic        StallM,
    output logic        regWriteW,
    output logic        MemToRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [2:0] LAT_M1 = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [4:0]  write_reg_q, write_reg_d;

    logic [31:0] ram [DEPTH];
    logic [AW-1:0] idx;
    logic        access;
    logic        is_load;
    logic        stall;
    logic        ram_we;

    // Byte address to word index; upper bits drop out so addresses wrap.
    assign idx     = ALUOutM[AW+1:2];
    assign access  = MemToRegM | MemWriteM;
    // A store wins when both load and store are flagged.
    assign is_load = MemToRegM & ~MemWriteM;
    assign PCSrcM  = BranchM & ZeroM;
    assign StallM  = stall;

    // Wait-state sequencer. The first stall cycle is spent in IDLE, so BUSY
    // only needs LAT-1 further stall cycles before the completion cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && (LAT != 0)) begin
                    stall   = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 3'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MEM/WB next values: a stalled cycle inserts a bubble, otherwise the
    // M inputs pass through and a completing load captures RAM data.
    always_comb begin
        reg_write_d  = regWriteM;
        mem_to_reg_d = MemToRegM;
        alu_out_d    = ALUOutM;
        write_reg_d  = WriteRegM;
        read_data_d  = read_data_q;
        if (stall) begin
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            alu_out_d    = alu_out_q;
            write_reg_d  = write_reg_q;
        end else if (access && is_load) begin
            read_data_d = ram[idx];
        end
    end

    // Gating with RST keeps an aborted access from touching the RAM.
    assign ram_we = ~stall & MemWriteM & ~RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= 32'd0;
            alu_out_q    <= 32'd0;
            write_reg_q  <= 5'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_out_q    <= alu_out_d;
            write_reg_q  <= write_reg_d;
        end
    end

    // Data RAM has no reset; contents are undefined until written.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[idx] <= WriteDataM;
        end
    end

    assign regWriteW = reg_write_q;
    assign MemToRegW = mem_to_reg_q;
    assign ReadDataW = read_data_q;
    assign ALUOutW   = alu_out_q;
    assign WriteRegW = write_reg_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
//
// Three instances share the clock and reset: LAT=2, LAT=0 and LAT=3, all
// with DEPTH=64. A table of instruction records is applied one by one;
// the expected W outputs are queued when an instruction is driven and
// popped when it completes. Hand-written sequences cover reset in the
// middle of a store and RAM retention across reset.
module tb_mem_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        br;
        logic        zr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wreg;
    } in_t;

    typedef struct packed {
        logic        pcsrc;
        logic        stall;
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
    } out_t;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
    } exp_t;

    typedef struct {
        int          dut;
        in_t         stim;
        logic [31:0] exp_rd;
        logic        exp_pc;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    in_t in0 = '0;
    in_t in1 = '0;
    in_t in2 = '0;

    logic        pc0, st0, rw0, mr0;
    logic [31:0] rd0, al0;
    logic [4:0]  wr0;
    logic        pc1, st1, rw1, mr1;
    logic [31:0] rd1, al1;
    logic [4:0]  wr1;
    logic        pc2, st2, rw2, mr2;
    logic [31:0] rd2, al2;
    logic [4:0]  wr2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 CLK = ~CLK;

    mem_stage #(.DEPTH(64), .LAT(2)) u_lat2 (
        .CLK(CLK), .RST(RST),
        .regWriteM(in0.rw), .MemToRegM(in0.m2r), .MemWriteM(in0.mw),
        .BranchM(in0.br), .ZeroM(in0.zr), .ALUOutM(in0.addr),
        .WriteDataM(in0.wdata), .WriteRegM(in0.wreg),
        .PCSrcM(pc0), .StallM(st0), .regWriteW(rw0), .MemToRegW(mr0),
        .ReadDataW(rd0), .ALUOutW(al0), .WriteRegW(wr0)
    );

    mem_stage #(.DEPTH(64), .LAT(0)) u_lat0 (
        .CLK(CLK), .RST(RST),
        .regWriteM(in1.rw), .MemToRegM(in1.m2r), .MemWriteM(in1.mw),
        .BranchM(in1.br), .ZeroM(in1.zr), .ALUOutM(in1.addr),
        .WriteDataM(in1.wdata), .WriteRegM(in1.wreg),
        .PCSrcM(pc1), .StallM(st1), .regWriteW(rw1), .MemToRegW(mr1),
        .ReadDataW(rd1), .ALUOutW(al1), .WriteRegW(wr1)
    );

    mem_stage #(.DEPTH(64), .LAT(3)) u_lat3 (
        .CLK(CLK), .RST(RST),
        .regWriteM(in2.rw), .MemToRegM(in2.m2r), .MemWriteM(in2.mw),
        .BranchM(in2.br), .ZeroM(in2.zr), .ALUOutM(in2.addr),
        .WriteDataM(in2.wdata), .WriteRegM(in2.wreg),
        .PCSrcM(pc2), .StallM(st2), .regWriteW(rw2), .MemToRegW(mr2),
        .ReadDataW(rd2), .ALUOutW(al2), .WriteRegW(wr2)
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic out_t get_out(input int d);
        case (d)
            0:       return {pc0, st0, rw0, mr0, rd0, al0, wr0};
            1:       return {pc1, st1, rw1, mr1, rd1, al1, wr1};
            default: return {pc2, st2, rw2, mr2, rd2, al2, wr2};
        endcase
    endfunction

    // Drives one instance and parks the others on all-zero inputs.
    task automatic set_in(input int d, input in_t v);
        in0 = (d == 0) ? v : '0;
        in1 = (d == 1) ? v : '0;
        in2 = (d == 2) ? v : '0;
    endtask

    function automatic in_t mk(input logic rw, input logic m2r, input logic mw,
                               input logic br, input logic zr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] wreg);
        in_t s;
        s.rw = rw; s.m2r = m2r; s.mw = mw; s.br = br; s.zr = zr;
        s.addr = addr; s.wdata = wdata; s.wreg = wreg;
        return s;
    endfunction

    function automatic vec_t vec(input int d, input in_t s,
                                 input logic [31:0] rd, input logic pc);
        vec_t v;
        v.dut = d; v.stim = s; v.exp_rd = rd; v.exp_pc = pc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_zero_state(input string tag, input int d);
        out_t o;
        o = get_out(d);
        checkOutput({tag, " stall"},     32'(o.stall), 32'd0);
        checkOutput({tag, " pcsrc"},     32'(o.pcsrc), 32'd0);
        checkOutput({tag, " regWriteW"}, 32'(o.rw),    32'd0);
        checkOutput({tag, " MemToRegW"}, 32'(o.m2r),   32'd0);
        checkOutput({tag, " ReadDataW"}, o.rd,         32'd0);
        checkOutput({tag, " ALUOutW"},   o.alu,        32'd0);
        checkOutput({tag, " WriteRegW"}, 32'(o.wr),    32'd0);
    endtask

    // Drives one instruction at a falling edge, counts stall cycles (each
    // must leave a bubble in MEM/WB) and compares the completed W outputs.
    task automatic applyStimulus(input int n, input vec_t v);
        out_t  o;
        exp_t  e;
        int    stalls;
        int    guard;
        string tag;
        tag = $sformatf("v%0d(lat%0d)", n, lat_of(v.dut));
        @(negedge CLK);
        set_in(v.dut, v.stim);
        e.rw  = v.stim.rw;
        e.m2r = v.stim.m2r;
        e.rd  = v.exp_rd;
        e.alu = v.stim.addr;
        e.wr  = v.stim.wreg;
        sb.push_back(e);
        #1;
        o = get_out(v.dut);
        checkOutput({tag, " pcsrc"}, 32'(o.pcsrc), 32'(v.exp_pc));
        stalls = 0;
        guard  = 0;
        while (o.stall === 1'b1 && guard < 16) begin
            stalls++;
            guard++;
            @(posedge CLK);
            #1;
            o = get_out(v.dut);
            checkOutput({tag, " bubble regWriteW"}, 32'(o.rw),  32'd0);
            checkOutput({tag, " bubble MemToRegW"}, 32'(o.m2r), 32'd0);
            checkOutput({tag, " pcsrc in stall"}, 32'(o.pcsrc), 32'(v.exp_pc));
        end
        if (guard >= 16) begin
            checkOutput({tag, " stall timeout"}, 32'(guard), 32'd0);
        end
        checkOutput({tag, " stall cycles"}, 32'(stalls),
                    (v.stim.m2r | v.stim.mw) ? 32'(lat_of(v.dut)) : 32'd0);
        @(posedge CLK);
        #1;
        o = get_out(v.dut);
        e = sb.pop_front();
        checkOutput({tag, " regWriteW"}, 32'(o.rw),  32'(e.rw));
        checkOutput({tag, " MemToRegW"}, 32'(o.m2r), 32'(e.m2r));
        checkOutput({tag, " ReadDataW"}, o.rd,       e.rd);
        checkOutput({tag, " ALUOutW"},   o.alu,      e.alu);
        checkOutput({tag, " WriteRegW"}, 32'(o.wr),  32'(e.wr));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // LAT=2 instance: ReadDataW holds across stores and non-access ops.
        vecs.push_back(vec(0, mk(1,0,0,0,0, 32'h55,  32'h0,        5'd3),  32'h0,        1'b0));
        vecs.push_back(vec(0, mk(0,0,1,0,0, 32'h10,  32'hDEADBEEF, 5'd0),  32'h0,        1'b0));
        vecs.push_back(vec(0, mk(1,1,0,0,0, 32'h10,  32'h0,        5'd8),  32'hDEADBEEF, 1'b0));
        vecs.push_back(vec(0, mk(0,0,1,0,0, 32'h100, 32'hA5A5A5A5, 5'd0),  32'hDEADBEEF, 1'b0));
        vecs.push_back(vec(0, mk(1,1,0,0,0, 32'h0,   32'h0,        5'd9),  32'hA5A5A5A5, 1'b0));
        vecs.push_back(vec(0, mk(0,0,1,0,0, 32'h3C,  32'h0BADF00D, 5'd0),  32'hA5A5A5A5, 1'b0));
        vecs.push_back(vec(0, mk(1,1,0,0,0, 32'h3,   32'h0,        5'd10), 32'hA5A5A5A5, 1'b0));
        vecs.push_back(vec(0, mk(0,0,0,1,1, 32'h8,   32'h0,        5'd0),  32'hA5A5A5A5, 1'b1));
        vecs.push_back(vec(0, mk(0,0,0,1,0, 32'h8,   32'h0,        5'd0),  32'hA5A5A5A5, 1'b0));
        vecs.push_back(vec(0, mk(1,1,0,1,1, 32'h3F,  32'h0,        5'd11), 32'h0BADF00D, 1'b1));
        vecs.push_back(vec(0, mk(0,1,1,0,0, 32'h20,  32'h77777777, 5'd12), 32'h0BADF00D, 1'b0));
        vecs.push_back(vec(0, mk(1,1,0,0,0, 32'h20,  32'h0,        5'd13), 32'h77777777, 1'b0));
        vecs.push_back(vec(0, mk(1,1,0,0,0, 32'h13,  32'h0,        5'd14), 32'hDEADBEEF, 1'b0));
        // LAT=0 instance: no stalls, back-to-back store/load.
        vecs.push_back(vec(1, mk(0,0,1,0,0, 32'h4,   32'h12345678, 5'd0),  32'h0,        1'b0));
        vecs.push_back(vec(1, mk(1,1,0,0,0, 32'h4,   32'h0,        5'd5),  32'h12345678, 1'b0));
        vecs.push_back(vec(1, mk(1,1,0,1,1, 32'h104, 32'h0,        5'd6),  32'h12345678, 1'b1));
        // LAT=3 instance: preload for the reset-abort sequence.
        vecs.push_back(vec(2, mk(0,0,1,0,0, 32'h40,  32'h11111111, 5'd7),  32'h0,        1'b0));

        repeat (2) @(posedge CLK);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_zero_state($sformatf("reset(lat%0d)", lat_of(d)), d);
        end
        @(negedge CLK);
        RST = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(i, vecs[i]);
        end

        // Store on LAT=3, reset asserted mid-cycle during the second stall.
        @(negedge CLK);
        set_in(2, mk(0,0,1,0,0, 32'h40, 32'h22222222, 5'd7));
        #1;
        checkOutput("abort stall cycle1", 32'(st2), 32'd1);
        @(posedge CLK);
        #1;
        checkOutput("abort stall cycle2", 32'(st2), 32'd1);
        checkOutput("abort pre-reset ALUOutW", al2, 32'h40);
        RST = 1'b1;
        set_in(2, '0);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_zero_state($sformatf("midreset(lat%0d)", lat_of(d)), d);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        sb.delete();

        // The aborted store must not have landed; RAM survives reset.
        applyStimulus(100, vec(2, mk(1,1,0,0,0, 32'h40, 32'h0, 5'd9), 32'h11111111, 1'b0));
        applyStimulus(101, vec(0, mk(1,1,0,0,0, 32'h10, 32'h0, 5'd2), 32'hDEADBEEF, 1'b0));
        applyStimulus(102, vec(1, mk(1,1,0,0,0, 32'h4,  32'h0, 5'd4), 32'h12345678, 1'b0));

        @(negedge CLK);
        set_in(0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
